feature_reader_2: RTL
=====================

Name: feature_reader_2

Overview:
- Read-side counterpart of the layer-2 feature-map writer. After a frame is stored in the dual-port feature RAM, this block reads it back through port A and streams it to the next conv layer.
- The stream carries one pixel per transfer under a valid/ready handshake.
- A small credit-controlled FIFO absorbs the RAM read latency, so downstream backpressure never drops or duplicates a pixel.

Parameters:
- DATA_WIDTH, 16, pixel width (from param_2.vh).
- POOL_ADDR_WIDTH, 10, feature RAM address width (from param_2.vh).
- NUM_PIXELS, 784, pixels per frame; must satisfy 1..2^POOL_ADDR_WIDTH.
- RD_LATENCY, 2, RAM cycles from rden_a sampled high to data_q_a valid.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+1 and a power of 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to read a frame; honoured only in IDLE.
- abort  in  1  synchronous flush to IDLE.
- base_addr  in  POOL_ADDR_WIDTH  first RAM address; latched on an accepted start.
- data_q_a  in  DATA_WIDTH  RAM port-A read data.
- rden_a  out  1  RAM port-A read enable (registered).
- address_a  out  POOL_ADDR_WIDTH  RAM port-A address (registered).
- wren_a, wren_b, rden_b  out  1 each  tied 0.
- data_out  out  DATA_WIDTH  pixel to the next layer (FIFO head).
- data_valid  out  1  data_out is valid.
- data_ready  in  1  downstream accepts the pixel.
- data_last  out  1  qualifies the final pixel of the frame.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; state goes to IDLE.
  - Issue count, in-flight shift register and FIFO pointers/count are cleared.
  - Reset applied mid-frame abandons the frame with no done pulse.
- States: IDLE -> READ -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 latches base_addr, clears issue_cnt, and moves to READ.
  - start in any other state is ignored.
- READ:
  - Issue rule: when inflight + fifo_count < FIFO_DEPTH, the next edge sets rden_a=1 and address_a = base + issue_cnt, then increments issue_cnt.
  - Otherwise rden_a=0 and address_a holds its value.
  - Address arithmetic is modulo 2^POOL_ADDR_WIDTH, so the address wraps silently.
  - After the NUM_PIXELS-th issue, move to DRAIN.
- In-flight tracking:
  - An RD_LATENCY-deep shift register of valid bits follows each issued read.
  - When its tail bit is 1, data_q_a is pushed into the FIFO on that edge.
  - The element pushed with the NUM_PIXELS-th read is tagged last.
- FIFO:
  - Registered; data_valid = (fifo_count != 0); data_out and data_last come from the head.
  - A transfer happens when data_valid & data_ready; pop and push may occur in the same cycle.
  - The credit rule guarantees no overflow, so a push never meets a full FIFO.
  - While data_valid=1 and data_ready=0, data_out and data_last hold stable.
- DRAIN: when the FIFO is empty, inflight is 0 and the last element has transferred, move to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. busy drops in the cycle done is high.
- Latency: start sampled at edge E0 -> rden_a high in cycle E1 -> first data_valid in cycle E1+RD_LATENCY+1 (cycle 4 with defaults).
- Throughput: with data_ready held at 1, one pixel per clock.
- Abort: in any non-IDLE state, abort=1 at an edge causes the following:
  - FIFO and in-flight bits are flushed, and in-flight RAM returns are discarded.
  - rden_a and data_valid are 0 in the next cycle.
  - State goes to IDLE with no done pulse.
  - abort has priority over every other event; abort in IDLE has no effect.
- NUM_PIXELS=1: the single pixel carries data_last, then done follows.

Decomposition:
- Shared package/include (param_2.vh): DATA_WIDTH, POOL_ADDR_WIDTH, NUM_PIXELS and the state encoding constants S_IDLE, S_READ, S_DRAIN, S_FIN.
- One sub-module: rd_credit_fifo, a synchronous FIFO with a last-bit sideband and a count output used for the credit check.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0 and busy=0; after release, idle until start.
- Nominal frame: NUM_PIXELS=8, base_addr=0, RAM model mem[i]=i+100, data_ready=1.
  - Stream is 100..107 in order, first data_valid 4 cycles after the start edge.
  - data_last only on 107; done pulse one cycle after the transfer of 107.
- Backpressure: data_ready=0 for cycles 6-15 of the nominal frame.
  - At most 4 reads outstanding or buffered; rden_a stays 0 once credits are exhausted.
  - data_out is stable throughout; the full sequence 100..107 completes with no gaps or duplicates.
- Wrap: base_addr=1022, NUM_PIXELS=4 -> address_a sequence 1022, 1023, 0, 1; data matches mem at those addresses.
- Abort: assert abort after the 3rd transfer.
  - data_valid and rden_a are 0 the next cycle, no done pulse.
  - A subsequent start with base_addr=0 returns 100..107 cleanly.
- Ignored start and mid-frame reset:
  - A start pulse while busy does not restart the address.
  - Driving reset=0 mid-frame clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/feature_reader_2_pkg.sv
// Shared constants for the layer-2 feature reader: default sizes, the
// controller state encoding and a small bit-count helper.
package feature_reader_2_pkg;

    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_POOL_ADDR_WIDTH = 10;
    localparam int DEF_NUM_PIXELS      = 784;
    localparam int DEF_RD_LATENCY      = 2;
    localparam int DEF_FIFO_DEPTH      = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Number of set bits in a (zero-extended) vector of in-flight flags.
    function automatic logic [7:0] count_ones(input logic [31:0] bits);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {7'd0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/feature_reader_2_rd_credit_fifo.sv
// Small synchronous FIFO holding RAM read returns until the next layer
// accepts them. Each entry carries a last-pixel sideband bit; the fill
// count is exported so the controller can meter reads against free space.
module rd_credit_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     push_last,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic                     head_last,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] last_q, last_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] count_q, count_d;
    logic pop_ok_s, push_ok_s;

    // Qualify pop/push: never pop empty, never push into a full FIFO unless a pop frees a slot.
    always_comb begin
        pop_ok_s  = pop && (count_q != (AW+1)'(0));
        push_ok_s = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok_s);
    end

    // Next-state for storage, pointers and fill count; flush empties the queue.
    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                data_d[wr_ptr_q] = push_data;
                last_d[wr_ptr_q] = push_last;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
        end
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {DW{1'b0}};
            end
            last_q   <= {DEPTH{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= (AW+1)'(0);
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/feature_reader_2.sv
// Layer-2 feature reader: reads a stored frame back through RAM port A and
// streams it pixel by pixel over a valid/ready handshake. Reads are issued
// only while the outstanding reads plus buffered pixels fit in the output
// FIFO, so downstream backpressure can never lose or repeat a pixel.
module feature_reader_2
    import feature_reader_2_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int POOL_ADDR_WIDTH = DEF_POOL_ADDR_WIDTH,
    parameter int NUM_PIXELS      = DEF_NUM_PIXELS,
    parameter int RD_LATENCY      = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [POOL_ADDR_WIDTH-1:0]  base_addr,
    input  logic [DATA_WIDTH-1:0]       data_q_a,
    output logic                        rden_a,
    output logic [POOL_ADDR_WIDTH-1:0]  address_a,
    output logic                        wren_a,
    output logic                        wren_b,
    output logic                        rden_b,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        data_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CNT_W  = POOL_ADDR_WIDTH + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]                 state_q, state_d;
    logic [POOL_ADDR_WIDTH-1:0] base_q, base_d;
    logic [POOL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]           issue_cnt_q, issue_cnt_d;
    logic                       rden_q, rden_d;
    logic                       rd_last_q, rd_last_d;
    logic [RD_LATENCY-1:0]      infl_q, infl_d;
    logic [RD_LATENCY-1:0]      infl_last_q, infl_last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [FCNT_W-1:0]          fifo_cnt_s;
    logic [DATA_WIDTH-1:0]      head_data_s;
    logic                       head_last_s;
    logic                       fifo_valid_s;
    logic                       pop_s;
    logic                       push_s;
    logic                       flush_s;
    logic                       can_issue_s;
    logic                       last_issue_s;
    logic                       frame_end_s;
    logic [7:0]                 inflight_s;
    logic [7:0]                 occupancy_s;

    // Credit bookkeeping: a read counts from the cycle rden_a is high until its
    // data lands in the FIFO; a pop on this edge already frees its slot.
    always_comb begin
        fifo_valid_s = (fifo_cnt_s != FCNT_W'(0));
        pop_s        = fifo_valid_s && data_ready;
        push_s       = infl_q[RD_LATENCY-1];
        flush_s      = abort && (state_q != S_IDLE);
        inflight_s   = {7'd0, rden_q} + count_ones(32'(infl_q));
        occupancy_s  = inflight_s + 8'(fifo_cnt_s) - {7'd0, pop_s};
        can_issue_s  = (occupancy_s < 8'(FIFO_DEPTH));
        last_issue_s = (issue_cnt_q == CNT_W'(NUM_PIXELS - 1));
        frame_end_s  = pop_s && head_last_s && (fifo_cnt_s == FCNT_W'(1)) &&
                       (inflight_s == 8'd0);
    end

    // Controller next-state: frame sequencing, read issue and in-flight tracking.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        rden_d      = 1'b0;
        rd_last_d   = 1'b0;
        done_d      = 1'b0;
        infl_d      = {RD_LATENCY{1'b0}};
        infl_last_d = {RD_LATENCY{1'b0}};

        // Valid bits follow each read the RAM has sampled until its data returns.
        infl_d[0]      = rden_q;
        infl_last_d[0] = rd_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            infl_d[i]      = infl_q[i-1];
            infl_last_d[i] = infl_last_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    issue_cnt_d = {CNT_W{1'b0}};
                    state_d     = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (can_issue_s) begin
                    rden_d      = 1'b1;
                    addr_d      = base_q + issue_cnt_q[POOL_ADDR_WIDTH-1:0];
                    rd_last_d   = last_issue_s;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (last_issue_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (frame_end_s) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything: drop reads in flight and return to idle.
        if (flush_s) begin
            state_d     = S_IDLE;
            rden_d      = 1'b0;
            rd_last_d   = 1'b0;
            done_d      = 1'b0;
            infl_d      = {RD_LATENCY{1'b0}};
            infl_last_d = {RD_LATENCY{1'b0}};
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    end

    // Controller registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= {POOL_ADDR_WIDTH{1'b0}};
            addr_q      <= {POOL_ADDR_WIDTH{1'b0}};
            issue_cnt_q <= {CNT_W{1'b0}};
            rden_q      <= 1'b0;
            rd_last_q   <= 1'b0;
            infl_q      <= {RD_LATENCY{1'b0}};
            infl_last_q <= {RD_LATENCY{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            rden_q      <= rden_d;
            rd_last_q   <= rd_last_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    rd_credit_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (data_q_a),
        .push_last (infl_last_q[RD_LATENCY-1]),
        .pop       (pop_s),
        .head_data (head_data_s),
        .head_last (head_last_s),
        .count     (fifo_cnt_s)
    );

    assign rden_a     = rden_q;
    assign address_a  = addr_q;
    assign wren_a     = 1'b0;
    assign wren_b     = 1'b0;
    assign rden_b     = 1'b0;
    assign data_valid = fifo_valid_s;
    assign data_out   = fifo_valid_s ? head_data_s : {DATA_WIDTH{1'b0}};
    assign data_last  = fifo_valid_s & head_last_s;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
